// File: rtl/or_gate_pkg.sv
// Shared constants, flag bundle type and popcount helper for the four-input OR stage.
package or_gate_pkg;

  localparam int OR_NUM_INPUTS = 4;
  localparam int OR_CNT_W      = 3;

  // Per-operand nonzero flags travel together with their population count.
  typedef struct packed {
    logic [OR_NUM_INPUTS-1:0] src;
    logic [OR_CNT_W-1:0]      cnt;
  } or_flags_t;

  // Number of set bits in a 4-bit flag vector, 0..4.
  function automatic logic [OR_CNT_W-1:0] popcount4(input logic [3:0] v);
    logic [OR_CNT_W-1:0] n_s;
    n_s = 3'd0;
    for (int i = 0; i < OR_NUM_INPUTS; i++) begin
      n_s = n_s + {2'b00, v[i]};
    end
    return n_s;
  endfunction

endpackage

// File: rtl/or_reg.sv
// WIDTH-bit D register with asynchronous active-low clear; captures every cycle.
module or_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d each rising edge; clear at once whenever reset_n goes low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= {WIDTH{1'b0}};
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/or_gate.sv
// Four-input bitwise OR with combinational and registered result, plus
// registered per-operand contribution flags and their count.
module or_gate
  import or_gate_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] result_comb,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       src,
  output logic [2:0]       active_cnt
);

  logic [WIDTH-1:0] or_next_s;
  or_flags_t        flags_next_s;
  or_flags_t        flags_r;

  // Next-state OR value, per-operand nonzero flags and their count.
  always_comb begin
    or_next_s        = a | b | c | d;
    flags_next_s.src = {(|d), (|c), (|b), (|a)};
    flags_next_s.cnt = popcount4(flags_next_s.src);
  end

  // The combinational view is never gated by clock or reset.
  assign result_comb = or_next_s;

  or_reg #(
    .WIDTH (WIDTH)
  ) u_result_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (or_next_s),
    .q       (result)
  );

  or_reg #(
    .WIDTH ($bits(or_flags_t))
  ) u_flags_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (flags_next_s),
    .q       (flags_r)
  );

  assign src        = flags_r.src;
  assign active_cnt = flags_r.cnt;

endmodule

// File: tb/tb_or_gate.sv
// Self-checking bench for or_gate at WIDTH=1 and WIDTH=8 against a behavioural model.
module tb_or_gate;

  logic       clk;
  logic       reset_n;
  logic       a1, b1, c1, d1;
  logic [7:0] a8, b8, c8, d8;

  logic       rc1, r1;
  logic [3:0] s1;
  logic [2:0] n1;
  logic [7:0] rc8, r8;
  logic [3:0] s8;
  logic [2:0] n8;

  int checks = 0;
  int errors = 0;

  or_gate #(.WIDTH(1)) dut1 (
    .clk (clk), .reset_n (reset_n),
    .a (a1), .b (b1), .c (c1), .d (d1),
    .result_comb (rc1), .result (r1), .src (s1), .active_cnt (n1)
  );

  or_gate #(.WIDTH(8)) dut8 (
    .clk (clk), .reset_n (reset_n),
    .a (a8), .b (b8), .c (c8), .d (d8),
    .result_comb (rc8), .result (r8), .src (s8), .active_cnt (n8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: operands as plain integers.
  function automatic int m_or(input int va, vb, vc, vd);
    return va | vb | vc | vd;
  endfunction

  function automatic int m_src(input int va, vb, vc, vd);
    int s;
    s = 0;
    if (va != 0) s += 1;
    if (vb != 0) s += 2;
    if (vc != 0) s += 4;
    if (vd != 0) s += 8;
    return s;
  endfunction

  function automatic int m_cnt(input int va, vb, vc, vd);
    int n;
    n = 0;
    if (va != 0) n++;
    if (vb != 0) n++;
    if (vc != 0) n++;
    if (vd != 0) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Combinational outputs against the current inputs.
  task automatic chk_comb(input string tag);
    #1;
    chk({tag, ".rc1"}, 32'(rc1), 32'(m_or(a1, b1, c1, d1)));
    chk({tag, ".rc8"}, 32'(rc8), 32'(m_or(a8, b8, c8, d8)));
  endtask

  // Take one edge and compare registered outputs with the pre-edge inputs.
  task automatic cycle(input string tag);
    int e_r1, e_s1, e_n1, e_r8, e_s8, e_n8;
    e_r1 = m_or(a1, b1, c1, d1);  e_s1 = m_src(a1, b1, c1, d1);  e_n1 = m_cnt(a1, b1, c1, d1);
    e_r8 = m_or(a8, b8, c8, d8);  e_s8 = m_src(a8, b8, c8, d8);  e_n8 = m_cnt(a8, b8, c8, d8);
    if (!reset_n) begin
      e_r1 = 0; e_s1 = 0; e_n1 = 0; e_r8 = 0; e_s8 = 0; e_n8 = 0;
    end
    @(posedge clk);
    #1;
    chk({tag, ".r1"}, 32'(r1), 32'(e_r1));
    chk({tag, ".s1"}, 32'(s1), 32'(e_s1));
    chk({tag, ".n1"}, 32'(n1), 32'(e_n1));
    chk({tag, ".r8"}, 32'(r8), 32'(e_r8));
    chk({tag, ".s8"}, 32'(s8), 32'(e_s8));
    chk({tag, ".n8"}, 32'(n8), 32'(e_n8));
  endtask

  task automatic set1(input logic [3:0] v);
    {d1, c1, b1, a1} = v;
  endtask

  task automatic set8(input logic [7:0] va, vb, vc, vd);
    a8 = va; b8 = vb; c8 = vc; d8 = vd;
  endtask

  initial begin
    reset_n = 1'b0;
    set1(4'b1111);
    set8(8'hFF, 8'hFF, 8'hFF, 8'hFF);

    // Reset held low while inputs toggle: registers stay clear, comb follows.
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        set1(4'b1111); set8(8'h01, 8'h01, 8'h01, 8'h01);
      end else begin
        set1(4'b0000); set8(8'h00, 8'h00, 8'h00, 8'h00);
      end
      chk_comb("rst_comb");
      cycle("rst_hold");
    end
    set1(4'b1111);
    chk_comb("rst_comb_ones");
    chk("rst_rc1_one", 32'(rc1), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Single operand c on WIDTH=1.
    #1;
    set1(4'b0100);
    set8(8'h00, 8'h00, 8'h20, 8'h00);
    chk_comb("single_comb");
    cycle("single");
    chk("single_src", 32'(s1), 32'h4);
    chk("single_cnt", 32'(n1), 32'd1);

    // All zero.
    set1(4'b0000);
    set8(8'h00, 8'h00, 8'h00, 8'h00);
    chk_comb("zero_comb");
    cycle("zero");
    chk("zero_r8", 32'(r8), 32'h0);

    // Exhaustive sweep of all 16 WIDTH=1 combinations, one per cycle.
    for (int v = 0; v < 16; v++) begin
      set1(4'(v));
      set8(8'(v * 17), 8'(v), 8'h00, 8'(15 - v));
      chk_comb("sweep_comb");
      cycle("sweep");
    end

    // Randomised operands, biased towards zero so counts cover 0..4.
    for (int i = 0; i < 40; i++) begin
      set1(4'($urandom_range(0, 15)));
      set8(($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom),
           ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom),
           ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom),
           ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom));
      chk_comb("rand_comb");
      cycle("rand");
    end

    // All ones.
    set1(4'b1111);
    set8(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    cycle("ones");
    chk("ones_r8", 32'(r8), 32'hFF);
    chk("ones_s8", 32'(s8), 32'hF);
    chk("ones_n8", 32'(n8), 32'd4);

    // WIDTH=8 directed pattern, then asynchronous clear mid-cycle.
    set1(4'b1101);
    set8(8'h01, 8'h10, 8'h00, 8'h80);
    cycle("w8");
    chk("w8_r8", 32'(r8), 32'h91);
    chk("w8_s8", 32'(s8), 32'hB);
    chk("w8_n8", 32'(n8), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("aclr_r8", 32'(r8), 32'h0);
    chk("aclr_s8", 32'(s8), 32'h0);
    chk("aclr_n8", 32'(n8), 32'd0);
    chk("aclr_r1", 32'(r1), 32'h0);
    chk("aclr_rc8", 32'(rc8), 32'h91);
    cycle("aclr_hold");

    // First edge after release captures the current inputs.
    @(negedge clk);
    reset_n = 1'b1;
    set1(4'b1000);
    set8(8'h00, 8'h42, 8'h00, 8'h00);
    cycle("release");
    chk("release_r8", 32'(r8), 32'h42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
